// File: rtl/frv_mem_responder.sv
// frv_mem_responder: single-ported word memory behind a request/grant,
// response/acknowledge bus with a two-entry response queue.
// Illegal accesses (misaligned or outside the mapped window) answer with
// error=1, rdata=0 and leave memory untouched.
// Optional build macro FRV_MEM_RESPONDER_STALL_EN adds a free-running 16-bit
// LFSR that withholds grant on pseudo-random cycles to exercise back-pressure.
module frv_mem_responder #(
    parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
    parameter int          MEM_WORDS = 1024
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        mem_req,
    input  logic        mem_wen,
    input  logic [3:0]  mem_strb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic        mem_gnt,
    output logic        mem_recv,
    input  logic        mem_ack,
    output logic        mem_error,
    output logic [31:0] mem_rdata
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    // One bit wider than the address so a window ending at 2^32 still compares
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

    // Byte-lane merge of new write data into an existing word
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0]      mem_r [MEM_WORDS];
    logic [31:0]      q_data_r [2];
    logic [1:0]       q_err_r;
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;

    logic [31:0]      offset_s;
    logic [IDX_W-1:0] idx_s;
    logic             addr_err_s;
    logic             space_s;
    logic             stall_s;
    logic             accept_s;
    logic             pop_s;
    logic [31:0]      resp_data_s;

`ifdef FRV_MEM_RESPONDER_STALL_EN
    logic [15:0]      lfsr_r;

    // Fibonacci LFSR (taps 16,14,13,11) stepping every cycle, seeded on reset
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end

    // Withhold grant whenever the two low LFSR bits are both zero
    always_comb begin
        stall_s = (lfsr_r[1:0] == 2'b00);
    end
`else
    // No back-pressure source in the default build
    always_comb begin
        stall_s = 1'b0;
    end
`endif

    // Address decode, handshake qualification and response data selection
    always_comb begin
        offset_s   = mem_addr - MEM_BASE;
        addr_err_s = (mem_addr[1:0] != 2'b00) ||
                     (mem_addr < MEM_BASE) ||
                     ({1'b0, offset_s} >= MEM_BYTES);
        idx_s      = offset_s[IDX_W+1:2];
        space_s    = (count_r != 2'd2);
        // Grant is gated by reset so it reads 0 for the whole reset period
        mem_gnt    = g_resetn & space_s & ~stall_s;
        accept_s   = mem_req & mem_gnt;
        pop_s      = (count_r != 2'd0) & mem_ack;
        if (addr_err_s || mem_wen) begin
            resp_data_s = 32'h0000_0000;
        end else begin
            resp_data_s = mem_r[idx_s];
        end
    end

    // Memory array write on a legal accepted write; contents survive reset
    always_ff @(posedge g_clk) begin
        if (accept_s && mem_wen && !addr_err_s) begin
            mem_r[idx_s] <= merge_bytes(mem_r[idx_s], mem_wdata, mem_strb);
        end
    end

    // Response queue: push on accept, pop on acknowledged response
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            q_data_r[0] <= 32'h0000_0000;
            q_data_r[1] <= 32'h0000_0000;
            q_err_r     <= 2'b00;
            wr_ptr_r    <= 1'b0;
            rd_ptr_r    <= 1'b0;
            count_r     <= 2'd0;
        end else begin
            if (accept_s) begin
                q_data_r[wr_ptr_r] <= resp_data_s;
                q_err_r[wr_ptr_r]  <= addr_err_s;
                wr_ptr_r           <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Present the queue head; outputs read zero while the queue is empty
    always_comb begin
        mem_recv = (count_r != 2'd0);
        if (mem_recv) begin
            mem_rdata = q_data_r[rd_ptr_r];
            mem_error = q_err_r[rd_ptr_r];
        end else begin
            mem_rdata = 32'h0000_0000;
            mem_error = 1'b0;
        end
    end

endmodule

// File: tb/tb_frv_mem_responder.sv
// Self-checking bench for frv_mem_responder: directed scenarios followed by
// randomized legal traffic, every cycle compared with a transaction-level model
// (reference memory array plus a queue of expected responses).
module tb_frv_mem_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 1024;

    logic        g_clk;
    logic        g_resetn;
    logic        mem_req;
    logic        mem_wen;
    logic [3:0]  mem_strb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_recv;
    logic        mem_ack;
    logic        mem_error;
    logic [31:0] mem_rdata;

    frv_mem_responder #(.MEM_BASE(BASE), .MEM_WORDS(WORDS)) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .mem_req  (mem_req),
        .mem_wen  (mem_wen),
        .mem_strb (mem_strb),
        .mem_wdata(mem_wdata),
        .mem_addr (mem_addr),
        .mem_gnt  (mem_gnt),
        .mem_recv (mem_recv),
        .mem_ack  (mem_ack),
        .mem_error(mem_error),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
    } resp_t;

    int          errors = 0;
    int          checks = 0;
    string       phase  = "init";
    logic [31:0] ref_mem [WORDS];
    resp_t       exp_q [$];
    logic [15:0] m_lfsr;

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // Reference stall generator: the LFSR recurrence as stated for the stall option
    always @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) m_lfsr <= 16'hACE1;
        else           m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 32'(WORDS * 4));
    endfunction

    function automatic bit exp_gnt();
        bit g;
        g = (exp_q.size() < 2);
`ifdef FRV_MEM_RESPONDER_STALL_EN
        if (m_lfsr[1:0] == 2'b00) g = 1'b0;
`endif
        return g;
    endfunction

    // One bus cycle: drive, check outputs against the model, clock, update model
    task automatic cyc(input logic req, input logic wen, input logic [3:0] strb,
                       input logic [31:0] wdata, input logic [31:0] addr,
                       input logic ack, output logic accepted);
        bit    g;
        bit    pop;
        bit    bad;
        int    idx;
        resp_t r;
        mem_req = req; mem_wen = wen; mem_strb = strb;
        mem_wdata = wdata; mem_addr = addr; mem_ack = ack;
        #2;
        g = exp_gnt();
        chk("gnt", {31'b0, mem_gnt}, {31'b0, g});
        if (exp_q.size() > 0) begin
            chk("recv",  {31'b0, mem_recv},  32'd1);
            chk("rdata", mem_rdata,          exp_q[0].data);
            chk("error", {31'b0, mem_error}, {31'b0, exp_q[0].err});
        end else begin
            chk("recv",  {31'b0, mem_recv},  32'd0);
            chk("rdata", mem_rdata,          32'd0);
            chk("error", {31'b0, mem_error}, 32'd0);
        end
        accepted = req & g;
        pop = (exp_q.size() > 0) && ack;
        bad = addr_bad(addr);
        idx = bad ? 0 : int'((addr - BASE) >> 2);
        r.err  = bad;
        r.data = (bad || wen) ? 32'd0 : ref_mem[idx];
        @(posedge g_clk);
        if (pop) void'(exp_q.pop_front());
        if (accepted) begin
            exp_q.push_back(r);
            if (wen && !bad) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        #1;
    endtask

    // Issue one request and hold it until accepted, within a cycle budget
    task automatic xact(input logic wen, input logic [3:0] strb, input logic [31:0] wdata,
                        input logic [31:0] addr, input logic ack);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            cyc(1'b1, wen, strb, wdata, addr, ack, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL %s/accept_timeout observed=no-grant expected=grant", phase);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, acc);
    endtask

    initial begin
        logic        acc;
        int          k;
        int          n;
        logic [31:0] raddr [3];

        for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'd0;
        g_resetn = 1'b0; mem_req = 1'b0; mem_wen = 1'b0; mem_strb = 4'h0;
        mem_wdata = 32'd0; mem_addr = 32'd0; mem_ack = 1'b0;

        // Reset state
        phase = "reset";
        repeat (3) @(posedge g_clk);
        #3;
        mem_req = 1'b1;
        #1;
        chk("gnt_in_reset",   {31'b0, mem_gnt},   32'd0);
        chk("recv_in_reset",  {31'b0, mem_recv},  32'd0);
        chk("rdata_in_reset", mem_rdata,          32'd0);
        chk("error_in_reset", {31'b0, mem_error}, 32'd0);
        mem_req = 1'b0;
        @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        cyc(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, acc);   // gnt=1 right after release

        // Preload words 0..63 so every later read has a known value
        phase = "preload";
        for (int i = 0; i < 64; i++) xact(1'b1, 4'hF, $urandom, BASE + 32'(i * 4), 1'b1);
        idle(2);

        phase = "wr_rd";
        xact(1'b1, 4'hF, 32'hDEAD_BEEF, 32'h8000_0010, 1'b1);
        xact(1'b0, 4'h0, 32'd0,         32'h8000_0010, 1'b1);
        idle(2);

        phase = "strobes";
        xact(1'b1, 4'hF,    32'h1122_3344, 32'h8000_0020, 1'b1);
        xact(1'b1, 4'b0101, 32'hAABB_CCDD, 32'h8000_0020, 1'b1);
        xact(1'b1, 4'h0,    32'hFFFF_FFFF, 32'h8000_0020, 1'b1);
        xact(1'b0, 4'h0,    32'd0,         32'h8000_0020, 1'b1);
        idle(2);
        chk("strobe_model", ref_mem[8], 32'h11BB_33DD);

        phase = "errors";
        xact(1'b0, 4'h0, 32'd0,         32'h8000_0002, 1'b1);
        xact(1'b0, 4'h0, 32'd0,         32'h0000_0000, 1'b1);
        xact(1'b1, 4'hF, 32'h5555_5555, 32'h8000_1000, 1'b1);
        xact(1'b1, 4'hF, 32'h6666_6666, 32'h8000_0011, 1'b1);
        xact(1'b0, 4'h0, 32'd0,         32'h8000_0000, 1'b1);
        xact(1'b0, 4'h0, 32'd0,         32'h8000_0010, 1'b1);
        xact(1'b0, 4'h0, 32'd0,         32'h8000_0FFC, 1'b1);
        idle(2);

        // Back-pressure: hold ack low over three reads, then drain
        phase = "backpressure";
        raddr[0] = 32'h8000_0004; raddr[1] = 32'h8000_0008; raddr[2] = 32'h8000_000C;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            cyc(k < 3, 1'b0, 4'h0, 32'd0, raddr[k < 3 ? k : 0], 1'b0, acc);
            if (acc) k++;
        end
        chk("queued", exp_q.size(), 32'd2);
        n = 0;
        while ((k < 3 || exp_q.size() > 0) && n < 20) begin
            cyc(k < 3, 1'b0, 4'h0, 32'd0, raddr[k < 3 ? k : 0], 1'b1, acc);
            if (acc) k++;
            n++;
        end
        chk("drained", k, 32'd3);
        idle(1);

        // Asynchronous reset with two responses outstanding
        phase = "midreset";
        cyc(1'b1, 1'b0, 4'h0, 32'd0, 32'h8000_0004, 1'b0, acc);
        n = 0;
        while (exp_q.size() < 2 && n < 20) begin
            cyc(1'b1, 1'b0, 4'h0, 32'd0, 32'h8000_0008, 1'b0, acc);
            n++;
        end
        chk("two_queued", exp_q.size(), 32'd2);
        #2;
        g_resetn = 1'b0;
        #1;
        chk("recv_async",  {31'b0, mem_recv},  32'd0);
        chk("rdata_async", mem_rdata,          32'd0);
        chk("error_async", {31'b0, mem_error}, 32'd0);
        chk("gnt_async",   {31'b0, mem_gnt},   32'd0);
        exp_q.delete();
        mem_req = 1'b0;
        @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        idle(3);
        xact(1'b0, 4'h0, 32'd0, 32'h8000_0020, 1'b1);   // memory survived reset
        idle(2);

        // Random legal traffic with random acknowledge
        phase = "random";
        for (int t = 0; t < 1000; t++) begin
            logic        w;
            logic [3:0]  s;
            logic [31:0] d;
            logic [31:0] a;
            w = 1'($urandom_range(0, 1));
            s = 4'($urandom_range(0, 15));
            d = $urandom;
            a = BASE + 32'($urandom_range(0, 63) * 4);
            acc = 1'b0;
            n = 0;
            while (!acc && n < 100) begin
                cyc(1'b1, w, s, d, a, 1'($urandom_range(0, 1)), acc);
                n++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL %s/accept_timeout observed=no-grant expected=grant", phase);
            end
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
